// File: rtl/cp0_regfile.sv
// cp0_regfile: Coprocessor-0 register file.
//   Holds Count(9), Compare(11), Status(12), Cause(13) and EPC(14) and
//   takes exceptions, eret and interrupts into account each cycle.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   rd_addr / cpdata     mfc0 read port (combinational, no write bypass)
//   wen, wr_addr,
//   w_cpdata             mtc0 write port
//   di, ei               clear / set Status.IE
//   eret                 return from exception (EXL <= 0, redirect to EPC)
//   exc_valid, exc_code,
//   exc_pc, exc_bd       exception commit from the pipeline
//   hw_int               level-sensitive, already-synchronised interrupt lines
//   redirect,
//   redirect_pc          one-cycle fetch redirect after exception / eret
//   int_req              registered pending-interrupt request
//   exl                  Status.EXL
module cp0_regfile #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int unsigned COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_addr,
    output logic [31:0] cpdata,
    input  logic        wen,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] w_cpdata,
    input  logic        di,
    input  logic        ei,
    input  logic        eret,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [5:0]  hw_int,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        int_req,
    output logic        exl
);

    localparam int unsigned     DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    // The exception state is Status.EXL itself.
    typedef enum logic {
        ST_NORMAL    = 1'b0,
        ST_EXCEPTION = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       compare_q, compare_d;
    logic [31:0]       epc_q, epc_d;
    logic [7:0]        im_q, im_d;
    logic              ie_q, ie_d;
    logic              bd_q, bd_d;
    logic              ti_q, ti_d;
    logic [5:0]        ip_hw_q, ip_hw_d;
    logic [1:0]        ip_sw_q, ip_sw_d;
    logic [4:0]        exc_code_q, exc_code_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              redirect_q, redirect_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic              int_req_q, int_req_d;
    logic              count_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_NORMAL;
            count_q       <= '0;
            compare_q     <= '0;
            epc_q         <= '0;
            im_q          <= '0;
            ie_q          <= 1'b0;
            bd_q          <= 1'b0;
            ti_q          <= 1'b0;
            ip_hw_q       <= '0;
            ip_sw_q       <= '0;
            exc_code_q    <= '0;
            div_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            int_req_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            compare_q     <= compare_d;
            epc_q         <= epc_d;
            im_q          <= im_d;
            ie_q          <= ie_d;
            bd_q          <= bd_d;
            ti_q          <= ti_d;
            ip_hw_q       <= ip_hw_d;
            ip_sw_q       <= ip_sw_d;
            exc_code_q    <= exc_code_d;
            div_q         <= div_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            int_req_q     <= int_req_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        compare_d     = compare_q;
        epc_d         = epc_q;
        im_d          = im_q;
        ie_d          = ie_q;
        bd_d          = bd_q;
        ti_d          = ti_q;
        ip_sw_d       = ip_sw_q;
        exc_code_d    = exc_code_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;

        // Free-running Count with prescaler; timer match only on an increment.
        count_tick = (div_q == DIV_LAST);
        if (count_tick) begin
            div_d   = '0;
            count_d = count_q + 32'd1;
        end else begin
            div_d   = div_q + DIV_W'(1);
        end
        if (count_tick && (count_q == compare_q)) begin
            ti_d = 1'b1;
        end

        if (exc_valid) begin
            // The faulting instruction does not commit: mtc0/di/ei/eret are dropped.
            // A nested exception keeps the original EPC/BD.
            if (state_q == ST_NORMAL) begin
                epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                bd_d  = exc_bd;
            end
            exc_code_d    = exc_code;
            state_d       = ST_EXCEPTION;
            redirect_d    = 1'b1;
            redirect_pc_d = EXC_VECTOR;
        end else begin
            if (wen) begin
                case (wr_addr)
                    5'd9: begin
                        count_d = w_cpdata;
                        div_d   = '0;
                    end
                    5'd11: begin
                        // Clearing TI here overrides a same-cycle match above.
                        compare_d = w_cpdata;
                        ti_d      = 1'b0;
                    end
                    5'd12: begin
                        im_d    = w_cpdata[15:8];
                        ie_d    = w_cpdata[0];
                        state_d = w_cpdata[1] ? ST_EXCEPTION : ST_NORMAL;
                    end
                    5'd13: ip_sw_d = w_cpdata[9:8];
                    5'd14: epc_d   = w_cpdata;
                    default: ;
                endcase
            end
            if (ei) ie_d = 1'b1;
            if (di) ie_d = 1'b0;
            if (eret) begin
                state_d       = ST_NORMAL;
                redirect_d    = 1'b1;
                redirect_pc_d = epc_q;
            end
        end

        // Sampled with the post-update TI so the timer and its interrupt line agree.
        ip_hw_d   = {hw_int[5] | ti_d, hw_int[4:0]};
        int_req_d = ie_d & (state_d == ST_NORMAL) & (|(im_d & {ip_hw_d, ip_sw_d}));
    end

    always_comb begin
        cpdata = '0;
        case (rd_addr)
            5'd9:  cpdata = count_q;
            5'd11: cpdata = compare_q;
            5'd12: cpdata = {16'b0, im_q, 6'b0, state_q == ST_EXCEPTION, ie_q};
            5'd13: cpdata = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b0};
            5'd14: cpdata = epc_q;
            default: ;
        endcase
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign int_req     = int_req_q;
    assign exl         = (state_q == ST_EXCEPTION);

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile (COUNT_DIV = 2).
module tb_cp0_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr;
    logic [31:0] cpdata;
    logic        wen;
    logic [4:0]  wr_addr;
    logic [31:0] w_cpdata;
    logic        di;
    logic        ei;
    logic        eret;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [5:0]  hw_int;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        int_req;
    logic        exl;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_regfile #(
        .EXC_VECTOR(32'hBFC0_0380),
        .COUNT_DIV (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .cpdata     (cpdata),
        .wen        (wen),
        .wr_addr    (wr_addr),
        .w_cpdata   (w_cpdata),
        .di         (di),
        .ei         (ei),
        .eret       (eret),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code),
        .exc_pc     (exc_pc),
        .exc_bd     (exc_bd),
        .hw_int     (hw_int),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .int_req    (int_req),
        .exl        (exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        #1;
        check(tag, cpdata, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        wen = 1'b1; wr_addr = addr; w_cpdata = data;
        step();
        wen = 1'b0;
    endtask

    task automatic raise(input logic [4:0] code, input logic [31:0] pc, input logic bd);
        exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
        step();
        exc_valid = 1'b0; exc_bd = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        step();
        eret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wen = 1'b0; wr_addr = '0; w_cpdata = '0;
        di = 1'b0; ei = 1'b0; eret = 1'b0; exc_valid = 1'b0; exc_code = '0;
        exc_pc = '0; exc_bd = 1'b0; hw_int = '0;

        // 1. reset
        step();
        step();
        rst = 1'b0;
        check_reg("rst_count",   5'd9,  32'h0);
        check_reg("rst_compare", 5'd11, 32'h0);
        check_reg("rst_status",  5'd12, 32'h0);
        check_reg("rst_cause",   5'd13, 32'h0);
        check_reg("rst_epc",     5'd14, 32'h0);
        check("rst_redirect", {31'b0, redirect}, 32'h0);
        check("rst_int_req",  {31'b0, int_req},  32'h0);

        // Move Compare away from Count so the timer stays quiet until section 4.
        mtc0(5'd11, 32'hFFFF_0000);

        // 2. exception entry / eret; write is not bypassed to the read port
        wen = 1'b1; wr_addr = 5'd12; w_cpdata = 32'h0000_8001;
        check_reg("no_bypass", 5'd12, 32'h0);
        step();
        wen = 1'b0;
        check_reg("status_wr", 5'd12, 32'h0000_8001);
        raise(5'd8, 32'h0040_0010, 1'b0);
        check_reg("exc_epc",   5'd14, 32'h0040_0010);
        check_reg("exc_cause", 5'd13, 32'h0000_0020);
        check("exc_exl",      {31'b0, exl},      32'h1);
        check("exc_redirect", {31'b0, redirect}, 32'h1);
        check("exc_rpc",      redirect_pc,       32'hBFC0_0380);
        step();
        check("redirect_pulse", {31'b0, redirect}, 32'h0);
        do_eret();
        check("eret_exl",      {31'b0, exl},      32'h0);
        check("eret_redirect", {31'b0, redirect}, 32'h1);
        check("eret_rpc",      redirect_pc,       32'h0040_0010);
        step();

        // 3. delay-slot exception, then nested exception
        raise(5'd12, 32'h0000_0100, 1'b1);
        check_reg("bd_epc",   5'd14, 32'h0000_00FC);
        check_reg("bd_cause", 5'd13, 32'h8000_0030);
        raise(5'd9, 32'h0000_0200, 1'b0);
        check_reg("nest_epc",   5'd14, 32'h0000_00FC);
        check_reg("nest_cause", 5'd13, 32'h8000_0024);
        check("nest_rpc", redirect_pc, 32'hBFC0_0380);
        do_eret();
        check("nest_eret_rpc", redirect_pc, 32'h0000_00FC);

        // 4. timer
        mtc0(5'd9,  32'h0);
        mtc0(5'd11, 32'h3);
        mtc0(5'd12, 32'h0000_8001);
        idle(5);
        check_reg("pre_match_count", 5'd9,  32'h3);
        check_reg("pre_match_cause", 5'd13, 32'h8000_0024);
        check("pre_match_int_req", {31'b0, int_req}, 32'h0);
        step();
        check_reg("match_cause", 5'd13, 32'hC000_8024);
        check_reg("match_count", 5'd9,  32'h4);
        check("match_int_req", {31'b0, int_req}, 32'h1);
        mtc0(5'd11, 32'd10);
        check_reg("ti_clear_cause", 5'd13, 32'h8000_0024);
        check("ti_clear_int_req", {31'b0, int_req}, 32'h0);
        mtc0(5'd9, 32'hFFFF_FFFF);
        check_reg("count_load", 5'd9, 32'hFFFF_FFFF);
        step();
        check_reg("count_hold", 5'd9, 32'hFFFF_FFFF);
        step();
        check_reg("count_wrap", 5'd9, 32'h0);

        // 5. same-cycle interactions
        wen = 1'b1; wr_addr = 5'd12; w_cpdata = 32'h0000_FF01;
        raise(5'd8, 32'h0000_0300, 1'b0);
        wen = 1'b0;
        check_reg("exc_blocks_wen", 5'd12, 32'h0000_8003);
        check_reg("exc5_cause",     5'd13, 32'h0000_0020);
        do_eret();
        check("eret5_rpc", redirect_pc, 32'h0000_0300);
        di = 1'b1;
        mtc0(5'd12, 32'h0000_0001);
        di = 1'b0;
        check_reg("di_over_wen", 5'd12, 32'h0);
        ei = 1'b1;
        step();
        ei = 1'b0;
        check_reg("ei_sets_ie", 5'd12, 32'h0000_0001);

        // 6. hardware interrupt, then reset during an exception
        mtc0(5'd11, 32'h8000_0000);
        mtc0(5'd12, 32'h0000_1001);
        check("int_idle", {31'b0, int_req}, 32'h0);
        hw_int = 6'b000100;
        step();
        check_reg("hw_ip_cause", 5'd13, 32'h0000_1020);
        check("hw_int_req", {31'b0, int_req}, 32'h1);
        hw_int = 6'b000000;
        step();
        check_reg("hw_drop_cause", 5'd13, 32'h0000_0020);
        check("hw_drop_int_req", {31'b0, int_req}, 32'h0);
        raise(5'd0, 32'h0000_0500, 1'b0);
        check("pre_rst_exl", {31'b0, exl}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reg("rst2_count",   5'd9,  32'h0);
        check_reg("rst2_compare", 5'd11, 32'h0);
        check_reg("rst2_status",  5'd12, 32'h0);
        check_reg("rst2_cause",   5'd13, 32'h0);
        check_reg("rst2_epc",     5'd14, 32'h0);
        check("rst2_exl",      {31'b0, exl},      32'h0);
        check("rst2_redirect", {31'b0, redirect}, 32'h0);
        check("rst2_rpc",      redirect_pc,       32'h0);
        check("rst2_int_req",  {31'b0, int_req},  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
